// File: rtl/dense_layer_axil_pkg.sv
// Shared AXI-Lite definitions for the dense-layer BAR0 block: response codes,
// register map (shared with the slave) and master FSM state encoding.
package dense_layer_axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axil_resp_e;

  localparam logic [7:0] REG_START        = 8'h00;
  localparam logic [7:0] REG_DEBUG_RST    = 8'h04;
  localparam logic [7:0] REG_DEBUG_COUNT  = 8'h08;
  localparam logic [7:0] REG_STATUS       = 8'h0C;
  localparam logic [7:0] REG_START_TIME_L = 8'h10;
  localparam logic [7:0] REG_START_TIME_H = 8'h14;
  localparam logic [7:0] REG_END_TIME_L   = 8'h18;
  localparam logic [7:0] REG_END_TIME_H   = 8'h1C;

  typedef logic [2:0] mst_state_t;

  localparam mst_state_t ST_IDLE = 3'd0;
  localparam mst_state_t ST_WR   = 3'd1;
  localparam mst_state_t ST_WR_B = 3'd2;
  localparam mst_state_t ST_RD_A = 3'd3;
  localparam mst_state_t ST_RD_R = 3'd4;
  localparam mst_state_t ST_RSP  = 3'd5;

endpackage

// File: rtl/dense_layer_axil_master.sv
// Single-outstanding AXI-Lite initiator: turns a valid/ready command into one
// AW/W/B or AR/R transaction and returns a registered valid/ready response.
module dense_layer_axil_master
  import dense_layer_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  mst_state_t            state_q, state_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                  bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  axil_resp_e            rsp_resp_q, rsp_resp_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  aw_hs, w_hs, bus_busy;

  assign aw_hs    = awvalid_q & m_awready;
  assign w_hs     = wvalid_q & m_wready;
  assign bus_busy = (state_q == ST_WR) || (state_q == ST_WR_B) ||
                    (state_q == ST_RD_A) || (state_q == ST_RD_R);

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;

    // Saturating watchdog; the transaction keeps running so the bus stays legal.
    if (bus_busy) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX - 1'b1) timeout_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          timeout_d = 1'b0;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_A;
          end
        end
      end
      ST_WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (m_bvalid) begin
          rsp_resp_d  = axil_resp_e'(m_bresp);
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          rsp_valid_d = 1'b1;
          bready_d    = 1'b0;
          state_d     = ST_RSP;
        end
      end
      ST_RD_A: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (m_rvalid) begin
          rsp_resp_d  = axil_resp_e'(m_rresp);
          rsp_rdata_d = m_rdata;
          rsp_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          rready_d    = 1'b0;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign timeout_err = timeout_q;
  assign m_awaddr    = awaddr_q;
  assign m_awvalid   = awvalid_q;
  assign m_wdata     = wdata_q;
  assign m_wstrb     = wstrb_q;
  assign m_wvalid    = wvalid_q;
  assign m_bready    = bready_q;
  assign m_araddr    = araddr_q;
  assign m_arvalid   = arvalid_q;
  assign m_rready    = rready_q;

endmodule
